uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NumReq, default 2: number of byte-stream requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter LockChar, default 8'h0A: byte whose acceptance ends a message and releases the grant.
REQ-003 Parameter TimeoutCycles, default 65535: idle cycles of the granted requester before the grant is forcibly released (range 1..2^20).
REQ-004 clk_i  input  1  system clock; the block uses one clock.
REQ-005 reset_i  input  1  reset, asynchronous and active-high.
REQ-006 req_data_i  input  NumReq x 8  per-requester byte.
REQ-007 req_valid_i  input  NumReq  per-requester byte valid.
REQ-008 req_ready_o  output  NumReq  per-requester accept strobe.
REQ-009 uart_data_o  output  8  byte to UART data_i.
REQ-010 uart_valid_o  output  1  to UART data_valid_i.
REQ-011 uart_ready_i  input  1  from UART data_in_ready_o; high means the UART accepts a byte.
REQ-012 grant_o  output  NumReq  one-hot current owner; all-zero when idle.
REQ-013 busy_o  output  1  high when the state is not IDLE or the output register is full.

Function
REQ-014 A requester byte transfers on a cycle where req_valid_i[i] and req_ready_o[i] are both high.
REQ-015 A UART byte transfers on a cycle where uart_valid_o and uart_ready_i are both high.
REQ-016 States are IDLE and LOCKED.
REQ-017 In IDLE, when any req_valid_i bit is high, the block registers a round-robin winner into grant_o and enters LOCKED on the next edge.
- The search starts at the index one above the last winner (index 0 after reset) and wraps modulo NumReq.
REQ-018 In IDLE, all req_ready_o bits are 0.
REQ-019 In LOCKED, req_ready_o[g] = (output register empty) OR uart_ready_i, where g is the granted index.
- All other req_ready_o bits are 0.
- req_data_i and req_valid_i of non-granted requesters are ignored.
REQ-020 A one-byte output register drives uart_data_o and uart_valid_o.
- A byte accepted at edge N is presented at edge N with uart_valid_o high in cycle N+1.
- The register clears on a UART transfer with no simultaneous refill.
- On a UART transfer with a simultaneous accept, the register loads the new byte and uart_valid_o stays high.
REQ-021 uart_data_o holds stable while uart_valid_o is high and uart_ready_i is low.
REQ-022 Accepting a byte equal to LockChar from the granted requester releases the grant.
- grant_o becomes all-zero and the state becomes IDLE at that edge.
- The LockChar byte still drains from the output register.
REQ-023 A timeout counter resets to 0 on every accepted byte.
- It increments each LOCKED cycle in which req_valid_i[g] is low.
- On reaching TimeoutCycles, the block enters IDLE and clears grant_o.
REQ-024 The counter width is clog2(TimeoutCycles+1) and the counter saturates; it never wraps.
REQ-025 Re-arbitration from IDLE may occur while the output register still holds a byte.
- A new owner's first byte waits per REQ-019, so bytes are never reordered, dropped or duplicated.
REQ-026 A requester that keeps valid high after its LockChar byte re-competes in round-robin order and does not win back-to-back while another requester is waiting.

Reset
REQ-027 Asserting reset_i at any time, including mid-message, forces the following, discarding any held byte:
- state IDLE, grant_o 0, req_ready_o 0, uart_valid_o 0, uart_data_o 8'h00
- busy_o 0, round-robin pointer 0, timeout counter 0

Structure
REQ-028 cpu_reg_package holds UartArbNumReq and UartArbLockChar; the top-level instance uses these.
REQ-029 One sub-module, rr_priority_pick, holds the combinational round-robin winner selection (request vector, pointer -> one-hot winner); all state stays in uart_tx_arbiter.

Verification
REQ-030 Reset released, req0 sends "AB\n", uart_ready_i always 1 -> UART sees 8'h41, 8'h42, 8'h0A in consecutive cycles; grant_o returns to 0 after 8'h0A.
REQ-031 req0 "ab\n" and req1 "XY\n" raised in the same cycle -> UART sees "ab\n" then "XY\n" with no interleaving; grant order 01 then 10.
REQ-032 uart_ready_i low for 20 cycles while byte 8'h55 is held -> uart_data_o stays 8'h55, uart_valid_o stays 1, req_ready_o[g] stays 0; the byte transfers exactly once after release.
REQ-033 TimeoutCycles=16, req1 sends "Q" then drops valid -> grant released after 16 idle cycles; a pending req0 wins next.
REQ-034 reset_i pulsed mid-message with a byte held -> all outputs at reset values within the same cycle; next message starts cleanly from requester 0.
REQ-035 Random stress on both requesters with random uart_ready_i for 10000 cycles -> per-requester scoreboard shows no lost, duplicated or reordered bytes.

Source files
------------

// File: rtl/cpu_reg_package.sv
// rtl/cpu_reg_package.sv - shared constants and types for the UART transmit arbiter
package cpu_reg_package;

  // Number of byte-stream requesters sharing the UART transmitter
  localparam int UartArbNumReq = 2;

  // Byte whose acceptance closes a message and frees the transmitter
  localparam logic [7:0] UartArbLockChar = 8'h0A;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner selection
//
// Ports:
//   req  NumReq  request vector
//   ptr  IdxW    index where the search starts (wraps modulo NumReq)
//   win  NumReq  one-hot winner, all-zero when no request
module rr_priority_pick #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] win
);

  int j;

  // Walk from the farthest offset down to offset 0 so that the requester
  // nearest the pointer is the last one written and therefore wins.
  always_comb begin
    win = '0;
    j   = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NumReq;
      if (req[j]) begin
        win    = '0;
        win[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-locked round-robin arbiter in front of one UART transmitter
//
// Ports:
//   clk_i         system clock
//   reset_i       asynchronous active-high reset
//   req_data_i    NumReq x 8 requester bytes (requester i at bits 8i+7:8i)
//   req_valid_i   per-requester byte valid
//   req_ready_o   per-requester accept strobe
//   uart_data_o   byte to the UART
//   uart_valid_o  byte valid to the UART
//   uart_ready_i  UART can take a byte
//   grant_o       one-hot current owner, zero when idle
//   busy_o        locked or output register full
module uart_tx_arbiter
  import cpu_reg_package::*;
#(
  parameter int         NumReq        = UartArbNumReq,
  parameter logic [7:0] LockChar      = UartArbLockChar,
  parameter int         TimeoutCycles = 65535
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic [7:0]            uart_data_o,
  output logic                  uart_valid_o,
  input  logic                  uart_ready_i,
  output logic [NumReq-1:0]     grant_o,
  output logic                  busy_o
);

  localparam int IdxW  = $clog2(NumReq);
  localparam int TcntW = $clog2(TimeoutCycles + 1);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(TimeoutCycles);

  arb_state_e        state;
  logic [NumReq-1:0] grant_q;
  logic [IdxW-1:0]   gidx;
  logic [IdxW-1:0]   rr_ptr;
  logic [TcntW-1:0]  tcnt;
  logic [7:0]        out_data;
  logic              out_valid;

  logic [NumReq-1:0] pick;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   next_ptr;
  logic              g_valid;
  logic [7:0]        g_data;
  logic              can_take;
  logic              accept;
  logic              uart_xfer;

  rr_priority_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .win (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (pick[i]) pick_idx = IdxW'(i);
    end
  end

  assign next_ptr = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;

  assign g_valid  = req_valid_i[gidx];
  assign g_data   = req_data_i[8*gidx +: 8];

  // The output register can take a byte when empty or when it is being
  // drained in the same cycle, which keeps back-to-back bytes at full rate.
  assign can_take  = !out_valid || uart_ready_i;
  assign accept    = (state == ARB_LOCKED) && g_valid && can_take;
  assign uart_xfer = out_valid && uart_ready_i;

  assign req_ready_o  = ((state == ARB_LOCKED) && can_take) ? grant_q : '0;
  assign uart_data_o  = out_data;
  assign uart_valid_o = out_valid;
  assign grant_o      = grant_q;
  assign busy_o       = (state != ARB_IDLE) || out_valid;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ARB_IDLE;
      grant_q   <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      tcnt      <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= g_data;
        out_valid <= 1'b1;
      end else if (uart_xfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          // A held byte from the previous owner may still be draining; the
          // new owner is throttled by can_take so ordering is preserved.
          if (|req_valid_i) begin
            grant_q <= pick;
            gidx    <= pick_idx;
            rr_ptr  <= next_ptr;
            tcnt    <= '0;
            state   <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            tcnt <= '0;
            if (g_data == LockChar) begin
              state   <= ARB_IDLE;
              grant_q <= '0;
            end
          end else if (!g_valid) begin
            if (tcnt != TcntMax) tcnt <= tcnt + 1'b1;
            // Release on the edge where the count reaches TimeoutCycles.
            if (tcnt >= TcntMax - 1'b1) begin
              state   <= ARB_IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR = 2;

  logic           clk;
  logic           reset_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]  req_valid_i;
  logic [NR-1:0]  req_ready_o;
  logic [7:0]     uart_data_o;
  logic           uart_valid_o;
  logic           uart_ready_i;
  logic [NR-1:0]  grant_o;
  logic           busy_o;

  logic [7:0] rd [NR];
  logic       rv [NR];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_uart = 0;

  logic [7:0]    sb   [$];
  logic [7:0]    ulog [$];
  int            xcyc [$];
  logic [NR-1:0] glog [$];
  logic [NR-1:0] prev_grant = '0;

  uart_tx_arbiter #(
    .NumReq        (NR),
    .LockChar      (8'h0A),
    .TimeoutCycles (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .uart_data_o  (uart_data_o),
    .uart_valid_o (uart_valid_o),
    .uart_ready_i (uart_ready_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data_i  = {rd[1], rd[0]};
    req_valid_i = {rv[1], rv[0]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted requester bytes are queued, UART transfers pop them in order.
  always @(negedge clk) begin
    cyc++;
    if (!reset_i) begin
      if (uart_valid_o && uart_ready_i) begin
        n_uart++;
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else check("uart_byte", 32'(uart_data_o), 32'(sb.pop_front()));
        ulog.push_back(uart_data_o);
        xcyc.push_back(cyc);
      end
      for (int r = 0; r < NR; r++) begin
        if (req_valid_i[r] && req_ready_o[r]) begin
          sb.push_back(req_data_i[8*r +: 8]);
          n_acc++;
        end
      end
      if ((req_ready_o & ~grant_o) != '0)
        check("ready_outside_grant", 32'(req_ready_o & ~grant_o), 32'd0);
      if (grant_o != prev_grant && grant_o != '0) glog.push_back(grant_o);
    end
    prev_grant = grant_o;
  end

  task automatic put_byte(input int r, input logic [7:0] b, output bit ok);
    bit aborted;
    aborted = 1'b0;
    ok = 1'b0;
    rd[r] = b;
    rv[r] = 1'b1;
    for (int t = 0; t < 1000 && !ok && !aborted; t++) begin
      @(negedge clk);
      if (reset_i) aborted = 1'b1;
      else if (req_ready_o[r]) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    rv[r] = 1'b0;
    if (!aborted) check($sformatf("put_byte_done_r%0d", r), 32'(ok), 32'd1);
  endtask

  task automatic send(input int r, input string s);
    bit ok;
    for (int i = 0; i < s.len(); i++) begin
      put_byte(r, s[i], ok);
      if (!ok) break;
    end
  endtask

  task automatic wait_uvalid();
    int t;
    t = 0;
    while (!uart_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("uart_valid_seen", 32'(uart_valid_o), 32'd1);
  endtask

  task automatic stress(input int r, input int end_cyc);
    bit ok;
    int gap;
    int len;
    logic [7:0] b;
    while (cyc < end_cyc) begin
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) gap = 20;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0B;
        put_byte(r, b, ok);
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      put_byte(r, 8'h0A, ok);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_s;
    int    cnt55;
    int    n;
    int    end_cyc;

    reset_i      = 1'b1;
    uart_ready_i = 1'b1;
    for (int r = 0; r < NR; r++) begin
      rd[r] = 8'h00;
      rv[r] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_uvalid", 32'(uart_valid_o), 32'd0);
    check("rst_udata", 32'(uart_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous requests after reset: requester 0 first, whole messages only.
    glog.delete();
    ulog.delete();
    fork
      send(0, "ab\n");
      send(1, "XY\n");
    join
    repeat (4) @(posedge clk);
    #1;
    check("b_glog_size", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      check("b_grant_first", 32'(glog[0]), 32'b01);
      check("b_grant_second", 32'(glog[1]), 32'b10);
    end
    exp_s = "ab\nXY\n";
    check("b_ulog_size", 32'(ulog.size()), 32'd6);
    for (int i = 0; i < 6 && i < ulog.size(); i++)
      check($sformatf("b_stream_%0d", i), 32'(ulog[i]), 32'(exp_s[i]));

    // Single message with UART always ready: consecutive transfers.
    ulog.delete();
    xcyc.delete();
    send(0, "AB\n");
    @(negedge clk);
    check("a_grant_released", 32'(grant_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("a_xfer_count", 32'(xcyc.size()), 32'd3);
    if (xcyc.size() == 3) begin
      check("a_gap01", 32'(xcyc[1] - xcyc[0]), 32'd1);
      check("a_gap12", 32'(xcyc[2] - xcyc[1]), 32'd1);
      check("a_byte0", 32'(ulog[0]), 32'h41);
      check("a_byte1", 32'(ulog[1]), 32'h42);
      check("a_byte2", 32'(ulog[2]), 32'h0A);
    end
    check("a_idle_busy", 32'(busy_o), 32'd0);

    // UART back-pressure: 0x55 held stable for 20 cycles.
    ulog.delete();
    uart_ready_i = 1'b0;
    fork
      send(0, "U\n");
      begin
        wait_uvalid();
        repeat (20) begin
          check("c_hold_data", 32'(uart_data_o), 32'h55);
          check("c_hold_valid", 32'(uart_valid_o), 32'd1);
          check("c_hold_ready", 32'(req_ready_o[0]), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        uart_ready_i = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    cnt55 = 0;
    foreach (ulog[i]) if (ulog[i] == 8'h55) cnt55++;
    check("c_once", 32'(cnt55), 32'd1);
    check("c_total", 32'(ulog.size()), 32'd2);

    // Timeout: requester 1 goes quiet, requester 0 waits.
    glog.delete();
    send(1, "Q");
    fork
      send(0, "z\n");
      begin
        n = 0;
        while (n < 100) begin
          @(negedge clk);
          if (grant_o == 2'b10) n++;
          else break;
        end
        check("d_idle_cycles", 32'(n), 32'd16);
        check("d_released", 32'(grant_o), 32'd0);
        @(negedge clk);
        check("d_req0_wins", 32'(grant_o), 32'b01);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-message with a byte held in the output register.
    uart_ready_i = 1'b0;
    fork
      send(0, "mn\n");
      begin
        wait_uvalid();
        #2;
        reset_i = 1'b1;
        #1;
        check("e_rst_grant", 32'(grant_o), 32'd0);
        check("e_rst_ready", 32'(req_ready_o), 32'd0);
        check("e_rst_uvalid", 32'(uart_valid_o), 32'd0);
        check("e_rst_udata", 32'(uart_data_o), 32'd0);
        check("e_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
      end
    join
    sb.delete();
    uart_ready_i = 1'b1;
    glog.delete();
    @(posedge clk);
    #1;
    fork
      send(0, "ok\n");
      send(1, "p\n");
    join
    repeat (4) @(posedge clk);
    #1;
    check("e_glog_size", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      check("e_first_owner", 32'(glog[0]), 32'b01);
      check("e_second_owner", 32'(glog[1]), 32'b10);
    end
    check("e_sb_drained", 32'(sb.size()), 32'd0);

    // Random stress on both requesters with random UART back-pressure.
    n_acc  = 0;
    n_uart = 0;
    end_cyc = cyc + 10000;
    fork
      stress(0, end_cyc);
      stress(1, end_cyc);
      begin
        while (cyc < end_cyc) begin
          @(posedge clk);
          #1;
          uart_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk);
    #1;
    uart_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("f_sb_drained", 32'(sb.size()), 32'd0);
    check("f_counts", 32'(n_uart), 32'(n_acc));
    check("f_final_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
